// File: rtl/rf_wb_scheduler.sv
// Register-file write-back scheduler: round-robin arbitration of write-back
// requesters onto the single rd write port, plus a per-register pending scoreboard.
package pkg_parameters;
  localparam int NUM_REG = 32;
  localparam int XLEN    = 32;
endpackage

module rf_wb_scheduler #(
  parameter int NUM_REQ    = 3,
  parameter int NUM_OF_REG = pkg_parameters::NUM_REG,
  parameter int XLEN       = pkg_parameters::XLEN,
  parameter int AW         = $clog2(NUM_OF_REG)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic                    rf_web,
  output logic [AW-1:0]           rf_addr,
  output logic [XLEN-1:0]         rf_data,
  input  logic                    rsv_valid,
  input  logic [AW-1:0]           rsv_addr,
  output logic                    rsv_ready,
  input  logic [AW-1:0]           rs1_addr,
  input  logic [AW-1:0]           rs2_addr,
  input  logic [AW-1:0]           rs3_addr,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic                    rs3_busy,
  output logic                    wb_err
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]         ptr;
  logic [PW-1:0]         grant_idx;
  logic [PW-1:0]         cand;
  logic                  grant_any;
  logic [AW-1:0]         grant_addr;
  logic [XLEN-1:0]       grant_data;
  logic [NUM_OF_REG-1:0] pending;
  logic [NUM_OF_REG-1:0] pending_next;
  logic                  wr_clr;
  logic                  rsv_set;

  // Search begins one past the last winner, so the last winner has lowest priority.
  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = PW'((32'(ptr) + i) % NUM_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any       = 1'b1;
        grant_idx       = cand;
        req_ready[cand] = 1'b1;
      end
    end
  end

  assign grant_addr = req_addr[grant_idx*AW +: AW];
  assign grant_data = req_data[grant_idx*XLEN +: XLEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= PW'(NUM_REQ - 1);
      rf_web  <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      rf_web <= grant_any && (grant_addr != '0);
      if (grant_any)
        ptr <= grant_idx;
      if (grant_any && (grant_addr != '0)) begin
        rf_addr <= grant_addr;
        rf_data <= grant_data;
      end
    end
  end

  assign wr_clr    = rf_web && (rf_addr != '0);
  // Bypass: the register being retired this cycle may be re-reserved at once.
  assign rsv_ready = (rsv_addr == '0) || !pending[rsv_addr] || (rf_web && (rf_addr == rsv_addr));
  assign rsv_set   = rsv_valid && rsv_ready && (rsv_addr != '0);

  // Set is applied after clear so a same-edge set on the same register wins.
  always_comb begin
    pending_next = pending;
    if (wr_clr)
      pending_next[rf_addr] = 1'b0;
    if (rsv_set)
      pending_next[rsv_addr] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      wb_err  <= 1'b0;
    end else begin
      pending <= pending_next;
      if (wr_clr && !pending[rf_addr])
        wb_err <= 1'b1;
    end
  end

  assign rs1_busy = pending[rs1_addr];
  assign rs2_busy = pending[rs2_addr];
  assign rs3_busy = pending[rs3_addr];

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: arbiter/scoreboard model with a queue of
// expected register-file writes, checked by immediate assertions each cycle.
module tb_rf_wb_scheduler;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        rf_web;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        rsv_ready;
  logic [4:0]  rs1_addr, rs2_addr, rs3_addr;
  logic        rs1_busy, rs2_busy, rs3_busy;
  logic        wb_err;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_ptr;
  logic [31:0] m_pend;
  logic        m_err;
  logic        m_web;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [36:0] q[$];

  rf_wb_scheduler #(
    .NUM_REQ    (3),
    .NUM_OF_REG (32),
    .XLEN       (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rf_web    (rf_web),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs3_addr  (rs3_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .rs3_busy  (rs3_busy),
    .wb_err    (wb_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 2;
    m_pend  = '0;
    m_err   = 1'b0;
    m_web   = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    q.delete();
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model at the
  // edge, then check the registered write port just after the edge.
  task automatic step();
    logic [2:0] er;
    logic       ers;
    int         g;
    int         idx;
    logic [4:0] ga;
    @(negedge clk);
    g  = -1;
    er = '0;
    for (int i = 1; i <= 3; i++) begin
      idx = (m_ptr + i) % 3;
      if (g < 0 && req_valid[idx]) begin
        g       = idx;
        er[idx] = 1'b1;
      end
    end
    ers = (rsv_addr == 5'd0) || !m_pend[rsv_addr] || (m_web && m_waddr == rsv_addr);
    chk("req_ready", {29'd0, req_ready}, {29'd0, er});
    chk("rsv_ready", {31'd0, rsv_ready}, {31'd0, ers});
    chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, m_pend[rs1_addr]});
    chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, m_pend[rs2_addr]});
    chk("rs3_busy", {31'd0, rs3_busy}, {31'd0, m_pend[rs3_addr]});
    chk("wb_err", {31'd0, wb_err}, {31'd0, m_err});
    @(posedge clk);
    if (m_web && m_waddr != 5'd0) begin
      if (!m_pend[m_waddr]) m_err = 1'b1;
      m_pend[m_waddr] = 1'b0;
    end
    if (rsv_valid && ers && rsv_addr != 5'd0) m_pend[rsv_addr] = 1'b1;
    if (g >= 0) begin
      m_ptr = g;
      ga    = req_addr[g*5 +: 5];
      if (ga != 5'd0) q.push_back({ga, req_data[g*32 +: 32]});
    end
    #1;
    if (q.size() > 0) begin
      {m_waddr, m_wdata} = q.pop_front();
      m_web = 1'b1;
    end else begin
      m_web = 1'b0;
    end
    chk("rf_web", {31'd0, rf_web}, {31'd0, m_web});
    if (m_web) begin
      chk("rf_addr", {27'd0, rf_addr}, {27'd0, m_waddr});
      chk("rf_data", rf_data, m_wdata);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    rs1_addr  = '0;
    rs2_addr  = '0;
    rs3_addr  = '0;
    model_reset();
    #1;
    chk("reset rf_web", {31'd0, rf_web}, 32'd0);
    chk("reset rf_addr", {27'd0, rf_addr}, 32'd0);
    chk("reset rf_data", rf_data, 32'd0);
    chk("reset wb_err", {31'd0, wb_err}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Round-robin: reserve x1..x3, then keep all requesters valid.
    rs1_addr = 5'd1; rs2_addr = 5'd2; rs3_addr = 5'd3;
    for (int r = 1; r <= 3; r++) begin
      rsv_valid = 1'b1;
      rsv_addr  = 5'(r);
      step();
    end
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      rsv_valid = m_web;
      rsv_addr  = m_waddr;
      #1;
      if (k == 0) chk("rr first grant", {29'd0, req_ready}, 32'd1);
      if (k == 1) chk("rr second grant", {29'd0, req_ready}, 32'd2);
      step();
    end
    req_valid = '0;
    rsv_valid = m_web;
    rsv_addr  = m_waddr;
    step();
    rsv_valid = 1'b0;
    step();

    // Scoreboard timing on x5.
    rs1_addr  = 5'd5;
    rsv_valid = 1'b1;
    rsv_addr  = 5'd5;
    step();
    rsv_valid = 1'b0;
    #1 chk("x5 busy after rsv", {31'd0, rs1_busy}, 32'd1);
    step();
    step();
    req_addr  = {5'd0, 5'd5, 5'd0};
    req_data  = {32'd0, 32'hDEAD_BEEF, 32'd0};
    req_valid = 3'b010;
    step();
    req_valid = '0;
    #1;
    chk("x5 rf_web", {31'd0, rf_web}, 32'd1);
    chk("x5 rf_data", rf_data, 32'hDEAD_BEEF);
    chk("x5 busy before write edge", {31'd0, rs1_busy}, 32'd1);
    step();
    #1 chk("x5 busy after write edge", {31'd0, rs1_busy}, 32'd0);

    // WAW bypass on x7.
    rs2_addr  = 5'd7;
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    step();
    #1 chk("x7 rsv blocked", {31'd0, rsv_ready}, 32'd0);
    rsv_valid = 1'b0;
    req_addr  = {5'd0, 5'd0, 5'd7};
    req_data  = {32'd0, 32'd0, 32'h0000_0777};
    req_valid = 3'b001;
    step();
    req_valid = '0;
    rsv_valid = 1'b1;
    #1 chk("x7 rsv bypass", {31'd0, rsv_ready}, 32'd1);
    step();
    rsv_valid = 1'b0;
    #1;
    chk("x7 set wins", {31'd0, rs2_busy}, 32'd1);
    chk("x7 rsv blocked again", {31'd0, rsv_ready}, 32'd0);
    step();

    // Write to x0.
    rs1_addr  = 5'd0;
    req_addr  = {5'd0, 5'd0, 5'd0};
    req_data  = {32'hFFFF_FFFF, 32'd0, 32'd0};
    req_valid = 3'b100;
    #1 chk("x0 granted", {31'd0, req_ready[2]}, 32'd1);
    step();
    req_valid = '0;
    #1;
    chk("x0 rf_web", {31'd0, rf_web}, 32'd0);
    chk("x0 wb_err", {31'd0, wb_err}, 32'd0);
    chk("x0 busy", {31'd0, rs1_busy}, 32'd0);
    step();

    // Unreserved write to x9, then a legal write to x10.
    req_addr  = {5'd0, 5'd0, 5'd9};
    req_data  = {32'd0, 32'd0, 32'h0000_0999};
    req_valid = 3'b001;
    step();
    req_valid = '0;
    step();
    #1 chk("wb_err set", {31'd0, wb_err}, 32'd1);
    rsv_valid = 1'b1;
    rsv_addr  = 5'd10;
    step();
    rsv_valid = 1'b0;
    req_addr  = {5'd0, 5'd10, 5'd0};
    req_data  = {32'd0, 32'h0000_0AAA, 32'd0};
    req_valid = 3'b010;
    step();
    req_valid = '0;
    step();
    step();
    #1 chk("wb_err sticky", {31'd0, wb_err}, 32'd1);

    // Asynchronous reset while a write is in flight.
    rs1_addr  = 5'd12;
    rsv_valid = 1'b1;
    rsv_addr  = 5'd12;
    step();
    rsv_valid = 1'b0;
    req_addr  = {5'd0, 5'd0, 5'd12};
    req_data  = {32'd0, 32'd0, 32'h0000_0C0C};
    req_valid = 3'b001;
    step();
    req_valid = '0;
    #1 chk("pre-reset rf_web", {31'd0, rf_web}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async rst rf_web", {31'd0, rf_web}, 32'd0);
    chk("async rst rf_addr", {27'd0, rf_addr}, 32'd0);
    chk("async rst rf_data", rf_data, 32'd0);
    chk("async rst wb_err", {31'd0, wb_err}, 32'd0);
    chk("async rst busy", {31'd0, rs1_busy}, 32'd0);
    model_reset();
    req_addr  = '0;
    req_valid = 3'b111;
    #1;
    chk("post-reset grant", {29'd0, req_ready}, 32'd1);
    rst = 1'b0;
    step();
    step();
    req_valid = '0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Write-back scheduler for the integer register file. It shares the file's single write port between `NUM_REQ` write-back requesters (ALU, load unit, multi-cycle units) using round-robin arbitration and a registered output stage. It also keeps a per-register pending scoreboard so that issue logic can stall on RAW and WAW hazards. It sits between the execution units and the register file's `rd` write port.

## Interface
Parameters:
- `NUM_REQ`, 3, number of write-back requesters (2..8)
- `NUM_OF_REG`, `pkg_parameters::NUM_REG` (32), architectural register count; register x0 is hard-wired zero
- `XLEN`, `pkg_parameters::XLEN` (32), data width
- `AW`, `$clog2(NUM_OF_REG)` (5), register address width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  NUM_REQ  per-requester write-back valid
- `req_ready`  out  NUM_REQ  per-requester grant; transfer occurs when `valid&ready` is high at a rising edge
- `req_addr`  in  NUM_REQ×AW  destination register per requester
- `req_data`  in  NUM_REQ×XLEN  write data per requester
- `rf_web`  out  1  register file write enable
- `rf_addr`  out  AW  register file write address
- `rf_data`  out  XLEN  register file write data
- `rsv_valid`  in  1  issue reserves a destination register
- `rsv_addr`  in  AW  register being reserved
- `rsv_ready`  out  1  reservation accepted this cycle
- `rs1_addr`, `rs2_addr`, `rs3_addr`  in  AW each  source registers to check
- `rs1_busy`, `rs2_busy`, `rs3_busy`  out  1 each  source register has an outstanding write
- `wb_err`  out  1  sticky flag: a write-back targeted a register that was not pending

## Operation
- Arbiter: round-robin over `req_valid`. Search starts at `ptr+1` mod NUM_REQ, and the first valid requester is granted. `ptr` updates to the granted index only on a transfer. At most one grant per cycle (one-hot `req_ready`). `req_ready` is combinational from `req_valid` and `ptr`. A requester must hold `valid`, `addr` and `data` stable until it is granted.
- Output stage: on a transfer, register `rf_addr`/`rf_data` and set `rf_web=1`. With no transfer, `rf_web=0` next cycle and `rf_addr`/`rf_data` hold their values.
- Writes to x0: the transfer completes (ready is asserted) but `rf_web` stays 0, and neither the scoreboard nor `wb_err` is affected.
- Scoreboard: `pending[NUM_OF_REG-1:1]`; bit 0 always reads 0.
  - Set: `rsv_valid && rsv_ready && rsv_addr!=0`.
  - Clear: `rf_web && rf_addr!=0`, on the same edge at which the register file captures the write.
  - Set and clear of the same address on the same edge: set wins.
- `rsv_ready = !pending[rsv_addr] || (rf_web && rf_addr==rsv_addr)`. This provides a WAW stall with same-cycle bypass. `rsv_addr==0` is always ready.
- `rsN_busy = pending[rsN_addr]`, combinational; it does not include the bypass.
- `wb_err` sets when `rf_web && rf_addr!=0 && !pending[rf_addr]`. It clears only on reset.
- Reset (asynchronous, any cycle):
  - `pending=0`, `ptr=NUM_REQ-1` (requester 0 wins first), `rf_web=0`, `rf_addr=0`, `rf_data=0`, `wb_err=0`.
  - An in-flight output-stage write is discarded.

## Timing
- Transfer at edge E → `rf_web=1` in the cycle after E → register file written and pending bit cleared at edge E+1 → `busy` low and new data readable from edge E+1 onward.
- Throughput is one write per cycle, with no bubbles between back-to-back grants.
- Reservation at edge E → `busy=1` from edge E onward.
- Starvation bound: a valid requester is granted within NUM_REQ cycles.
- `rsv_ready`, `rsN_busy` and `req_ready` have zero latency (combinational from state and inputs).

## Test plan
- Reset: assert `rst` mid-transfer, with `rf_web=1` and pending bits set. Required: all outputs 0 immediately, `req_ready`=3'b001 when all three requesters are valid after release, and `wb_err`=0.
- Round-robin: all 3 requesters valid continuously, writing x1/x2/x3 (all reserved). Required: grants 0,1,2,0…; `rf_web` high every cycle; `rf_addr` sequence 1,2,3,1… one cycle after each grant.
- Scoreboard timing: reserve x5 at edge 0; requester 1 writes x5=0xDEADBEEF at edge 3. Required:
  - `rs1_busy` (`rs1_addr`=5) is 1 from edge 0 through edge 4 and 0 after edge 4.
  - `rf_web=1` with `rf_data`=0xDEADBEEF between edges 3 and 4.
- WAW bypass: x7 pending, `rsv_addr`=7, `rf_web=1` with `rf_addr`=7 in the same cycle. Required: `rsv_ready=1` and `pending[7]` remains 1 (set wins). With no write in that cycle, `rsv_ready=0`.
- x0 write: requester 2 writes x0=0xFFFFFFFF. Required: `req_ready[2]=1`, `rf_web` stays 0, `wb_err` stays 0, and `rs1_busy` for `rs1_addr`=0 is 0.
- Error flag: write x9 without a reservation. Required: `wb_err` is 1 after the register-file write edge and stays 1 through later legal writes until `rst`.
